// File: rtl/ysyx_24070014_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
//   arb_state_e : arbiter FSM states (idle, request issued, waiting for response)
//   OWN_IFU/LSU : owner / last-grant encodings (also the grant bit index)
//   ARB_TIMEOUT : WAIT-cycle limit, used only when YSYX_24070014_ARB_TIMEOUT_EN is defined
package ysyx_24070014_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } arb_state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam int unsigned ARB_TIMEOUT = 255;
  localparam int unsigned TIMEOUT_W   = $clog2(ARB_TIMEOUT + 1);

endpackage

// File: rtl/ysyx_24070014_rr_arb2.sv
// Two-input round-robin grant.
//   valid      in  [1:0] request valids, bit 0 = IFU, bit 1 = LSU
//   last_grant in        owner granted most recently (OWN_IFU / OWN_LSU)
//   grant      out [1:0] one-hot grant, 0 when no request is valid
module ysyx_24070014_rr_arb2
  import ysyx_24070014_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Tie: whoever was not granted last goes first.
      2'b11:   grant = (last_grant == OWN_LSU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_24070014_mem_arbiter.sv
// Arbitrates instruction-fetch (IFU) and load/store (LSU) requests onto a single
// memory port, one outstanding transaction at a time.
//   clk, reset            clock, asynchronous active-high reset
//   ifu_req_*             fetch request (valid/ready/addr)
//   lsu_req_*, lsu_w*     load/store request (valid/ready/addr/wen/wdata/wmask)
//   ifu/lsu_resp_valid    one-cycle response pulse to the owner
//   resp_rdata, resp_err  shared response data / timeout flag
//   mem_req_*, mem_*      latched request toward memory
//   mem_resp_valid/rdata  memory response
// Optional feature: define YSYX_24070014_ARB_TIMEOUT_EN to bound WAIT at ARB_TIMEOUT
// cycles and answer with resp_err=1; otherwise WAIT is unbounded and resp_err is 0.
module ysyx_24070014_mem_arbiter
  import ysyx_24070014_arb_pkg::*;
#(
  parameter int unsigned WORD_LEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [WORD_LEN-1:0]   ifu_addr,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [WORD_LEN-1:0]   lsu_addr,
  input  logic                  lsu_wen,
  input  logic [WORD_LEN-1:0]   lsu_wdata,
  input  logic [WORD_LEN/8-1:0] lsu_wmask,
  output logic                  ifu_resp_valid,
  output logic                  lsu_resp_valid,
  output logic [WORD_LEN-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [WORD_LEN-1:0]   mem_addr,
  output logic                  mem_wen,
  output logic [WORD_LEN-1:0]   mem_wdata,
  output logic [WORD_LEN/8-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [WORD_LEN-1:0]   mem_rdata
);

  arb_state_e            state_q;
  logic                  owner_q;
  logic                  last_q;
  logic [WORD_LEN-1:0]   addr_q;
  logic                  wen_q;
  logic [WORD_LEN-1:0]   wdata_q;
  logic [WORD_LEN/8-1:0] wmask_q;

  logic [1:0] grant;
  logic       accept;
  logic       mem_done;
  logic       timeout;
  logic       resp_fire;

  ysyx_24070014_rr_arb2 u_rr_arb2 (
    .valid      ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_q),
    .grant      (grant)
  );

  // Ready is masked during reset so every output reads 0 while it is held.
  assign ifu_req_ready = (state_q == StIdle) && !reset && grant[0];
  assign lsu_req_ready = (state_q == StIdle) && !reset && grant[1];
  assign accept        = ifu_req_ready || lsu_req_ready;

  assign mem_done = (state_q == StWait) && mem_resp_valid;

`ifdef YSYX_24070014_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q;
  // A real response arriving on the limit cycle takes priority over the timeout.
  assign timeout = (state_q == StWait) && !mem_resp_valid && (cnt_q == TIMEOUT_W'(ARB_TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  assign resp_fire      = mem_done || timeout;
  assign ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
  assign lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
  assign resp_err       = timeout;
  // Stores and timeouts return zero data.
  assign resp_rdata     = (mem_done && !wen_q) ? mem_rdata : '0;

  assign mem_req_valid = (state_q == StReq);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= OWN_IFU;
      last_q  <= OWN_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef YSYX_24070014_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StReq;
            owner_q <= lsu_req_ready ? OWN_LSU : OWN_IFU;
            last_q  <= lsu_req_ready ? OWN_LSU : OWN_IFU;
            if (lsu_req_ready) begin
              addr_q  <= lsu_addr;
              wen_q   <= lsu_wen;
              wdata_q <= lsu_wdata;
              wmask_q <= lsu_wmask;
            end else begin
              addr_q  <= ifu_addr;
              wen_q   <= 1'b0;
              wdata_q <= '0;
              wmask_q <= '0;
            end
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            state_q <= StWait;
`ifdef YSYX_24070014_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StWait: begin
          if (resp_fire) begin
            state_q <= StIdle;
          end
`ifdef YSYX_24070014_ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
